// File: rtl/dict_match_pipe_pkg.sv
// Shared definitions for the dictionary matcher.
//   - calc_nb / calc_loc_w / calc_mb_w : derive byte count, index width and
//     match-length width from the top-level parameters.
//   - DEF_* localparams                : the same values for the default
//                                        32-bit x 16-entry configuration.
//   - dict_result_t                    : {match_bytes, location, zero} for
//                                        the default configuration.
//   - lead_bytes_eq                    : count of leading (MSB-first) equal
//                                        bytes from a per-byte equality vector.
package dict_pkg;

    // Largest supported word is 512 bits (64 bytes).
    localparam int MAX_NB = 64;

    function automatic int calc_nb(input int word_w);
        return word_w / 8;
    endfunction

    function automatic int calc_loc_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_mb_w(input int word_w);
        return $clog2(word_w / 8 + 1);
    endfunction

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_DICT_ENTRY = 16;
    localparam int DEF_NB         = calc_nb(DEF_WORD_W);
    localparam int DEF_LOC_W      = calc_loc_w(DEF_DICT_ENTRY);
    localparam int DEF_MB_W       = calc_mb_w(DEF_WORD_W);

    typedef struct packed {
        logic [DEF_MB_W-1:0]  match_bytes;
        logic [DEF_LOC_W-1:0] location;
        logic                 zero;
    } dict_result_t;

    // eq[b] is 1 when byte b of the two words is equal; byte nb-1 is the MSB
    // byte. Counting starts at the MSB byte and stops at the first mismatch.
    function automatic int lead_bytes_eq(input logic [MAX_NB-1:0] eq, input int nb);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int b = MAX_NB - 1; b >= 0; b--) begin
            if (b < nb) begin
                if (run && eq[b]) begin
                    cnt = cnt + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dict_match_pipe_if.sv
// Handshake and data bundle of the dictionary matcher.
//   input side : i_valid, o_ready, i_word
//   output side: o_valid, i_ready, o_word, o_match_bytes, o_location, o_zero
//   status     : o_dict_count
// slave  modport: the matcher itself.
// master modport: the producer/consumer environment around it.
interface dict_match_pipe_if
    import dict_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int DICT_ENTRY = 16
);
    localparam int LOC_W = calc_loc_w(DICT_ENTRY);
    localparam int MB_W  = calc_mb_w(WORD_W);

    logic              i_valid;
    logic              o_ready;
    logic [WORD_W-1:0] i_word;
    logic              o_valid;
    logic              i_ready;
    logic [WORD_W-1:0] o_word;
    logic [MB_W-1:0]   o_match_bytes;
    logic [LOC_W-1:0]  o_location;
    logic              o_zero;
    logic [LOC_W:0]    o_dict_count;

    modport slave (
        input  i_valid, i_word, i_ready,
        output o_ready, o_valid, o_word, o_match_bytes, o_location, o_zero, o_dict_count
    );

    modport master (
        output i_valid, i_word, i_ready,
        input  o_ready, o_valid, o_word, o_match_bytes, o_location, o_zero, o_dict_count
    );
endinterface

// File: rtl/dict_match_pipe_matcher.sv
// dict_byte_matcher: compares one word against one dictionary entry.
//   word        : candidate word
//   entry       : stored dictionary word
//   entry_valid : entry holds real data; an invalid entry reports 0
//   match_bytes : number of equal bytes counted from the MSB byte down
module dict_byte_matcher
    import dict_pkg::*;
#(
    parameter int WORD_W = 32,
    localparam int NB    = calc_nb(WORD_W),
    localparam int MB_W  = calc_mb_w(WORD_W)
) (
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] entry,
    input  logic              entry_valid,
    output logic [MB_W-1:0]   match_bytes
);
    logic [NB-1:0]     byte_eq;
    logic [MAX_NB-1:0] byte_eq_ext;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign byte_eq[gi] = (word[gi*8 +: 8] == entry[gi*8 +: 8]);
        end
    endgenerate

    assign byte_eq_ext = MAX_NB'(byte_eq);

    always_comb begin
        match_bytes = '0;
        if (entry_valid) begin
            match_bytes = MB_W'(lead_bytes_eq(byte_eq_ext, NB));
        end
    end
endmodule

// File: rtl/dict_match_pipe.sv
// dict_match_pipe: two-stage dictionary matcher.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-low reset (also clears result outputs)
//   i_clear : synchronous flush of dictionary and both stages
//   bus     : slave side of dict_match_pipe_if (word in, result out, count)
// S1 registers an accepted word. S2 compares it against every entry,
// registers the best match and writes the dictionary on the same edge, so
// each word sees the update made by the word before it.
module dict_match_pipe
    import dict_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int DICT_ENTRY = 16,
    parameter int MIN_MATCH  = 2
) (
    input logic              i_clk,
    input logic              i_reset,
    input logic              i_clear,
    dict_match_pipe_if.slave bus
);
    localparam int NB    = calc_nb(WORD_W);
    localparam int LOC_W = calc_loc_w(DICT_ENTRY);
    localparam int MB_W  = calc_mb_w(WORD_W);

    // Pipeline state
    logic              s1_valid_reg;
    logic [WORD_W-1:0] s1_word_reg;
    logic              o_valid_reg;
    logic [WORD_W-1:0] o_word_reg;
    logic [MB_W-1:0]   o_mb_reg;
    logic [LOC_W-1:0]  o_loc_reg;
    logic              o_zero_reg;

    // Dictionary state
    logic [WORD_W-1:0]     dict_mem_reg [DICT_ENTRY];
    logic [DICT_ENTRY-1:0] valid_bits_reg;
    logic [LOC_W-1:0]      wp_reg;
    logic [LOC_W:0]        count_reg;

    logic advance2;
    logic ready;

    assign advance2 = ~o_valid_reg | bus.i_ready;
    assign ready    = ~s1_valid_reg | advance2;

    // Per-entry match lengths
    logic [MB_W-1:0] leaf_len [DICT_ENTRY];

    generate
        for (genvar gi = 0; gi < DICT_ENTRY; gi++) begin : g_entry
            dict_byte_matcher #(.WORD_W(WORD_W)) u_match (
                .word        (s1_word_reg),
                .entry       (dict_mem_reg[gi]),
                .entry_valid (valid_bits_reg[gi]),
                .match_bytes (leaf_len[gi])
            );
        end
    endgenerate

    // Pairwise max tree, reduced in place level by level. The left child
    // always covers lower indices, so keeping it on a tie gives the lowest
    // index among equal lengths.
    logic [MB_W-1:0]  red_len [DICT_ENTRY];
    logic [LOC_W-1:0] red_loc [DICT_ENTRY];
    logic [MB_W-1:0]  best_len;
    logic [LOC_W-1:0] best_loc;

    always_comb begin
        for (int i = 0; i < DICT_ENTRY; i++) begin
            red_len[i] = leaf_len[i];
            red_loc[i] = LOC_W'(i);
        end
        for (int w = DICT_ENTRY / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                if (red_len[2*i+1] > red_len[2*i]) begin
                    red_len[i] = red_len[2*i+1];
                    red_loc[i] = red_loc[2*i+1];
                end else begin
                    red_len[i] = red_len[2*i];
                    red_loc[i] = red_loc[2*i];
                end
            end
        end
        best_len = red_len[0];
        best_loc = red_loc[0];
    end

    // Stage-2 result and dictionary write decision
    logic            s1_zero;
    logic [MB_W-1:0] res_mb;
    logic [LOC_W-1:0] res_loc;
    logic            do_write;

    assign s1_zero = (s1_word_reg == '0);

    always_comb begin
        res_mb  = '0;
        res_loc = '0;
        if (!s1_zero && (best_len >= MB_W'(MIN_MATCH))) begin
            res_mb  = best_len;
            res_loc = best_loc;
        end
    end

    // Full matches are already stored; zero words are never stored.
    assign do_write = s1_valid_reg & advance2 & ~s1_zero & (res_mb != MB_W'(NB));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            s1_valid_reg   <= 1'b0;
            s1_word_reg    <= '0;
            o_valid_reg    <= 1'b0;
            o_word_reg     <= '0;
            o_mb_reg       <= '0;
            o_loc_reg      <= '0;
            o_zero_reg     <= 1'b0;
            valid_bits_reg <= '0;
            wp_reg         <= '0;
            count_reg      <= '0;
        end else if (i_clear) begin
            s1_valid_reg   <= 1'b0;
            o_valid_reg    <= 1'b0;
            valid_bits_reg <= '0;
            wp_reg         <= '0;
            count_reg      <= '0;
        end else begin
            if (ready) begin
                s1_valid_reg <= bus.i_valid;
                if (bus.i_valid) begin
                    s1_word_reg <= bus.i_word;
                end
            end
            if (advance2) begin
                o_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    o_word_reg <= s1_word_reg;
                    o_mb_reg   <= res_mb;
                    o_loc_reg  <= res_loc;
                    o_zero_reg <= s1_zero;
                end
            end
            if (do_write) begin
                valid_bits_reg[wp_reg] <= 1'b1;
                wp_reg                 <= wp_reg + 1'b1;
                if (count_reg != (LOC_W+1)'(DICT_ENTRY)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    end

    // Word storage carries no reset; the valid bits qualify every entry.
    always_ff @(posedge i_clk) begin
        if (do_write && i_reset && !i_clear) begin
            dict_mem_reg[wp_reg] <= s1_word_reg;
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_valid       = o_valid_reg;
    assign bus.o_word        = o_word_reg;
    assign bus.o_match_bytes = o_mb_reg;
    assign bus.o_location    = o_loc_reg;
    assign bus.o_zero        = o_zero_reg;
    assign bus.o_dict_count  = count_reg;
endmodule

// File: tb/tb_dict_match_pipe.sv
// Directed testbench for dict_match_pipe (32-bit words, 16 entries,
// minimum match 2). Inputs are driven on the falling edge, outputs sampled
// on the falling edge.
module tb_dict_match_pipe;
    import dict_pkg::*;

    logic clk;
    logic rst;
    logic clear;

    int errors = 0;
    int checks = 0;

    dict_match_pipe_if #(.WORD_W(32), .DICT_ENTRY(16)) bus ();

    dict_match_pipe #(
        .WORD_W     (32),
        .DICT_ENTRY (16),
        .MIN_MATCH  (2)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_clear (clear),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    dict_result_t got;
    logic [31:0]  got_word;
    logic [4:0]   got_cnt;
    int           got_lat;

    // Sends one word (called at a falling edge with i_ready = 1) and
    // captures its result.
    task automatic send_one(input logic [31:0] w);
        int guard;
        bus.i_valid = 1'b1;
        bus.i_word  = w;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        got_lat = 1;
        guard   = 0;
        while (!bus.o_valid && guard < 10) begin
            @(negedge clk);
            got_lat++;
            guard++;
        end
        checks++;
        if (bus.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout word=%h o_valid=%b required 1", w, bus.o_valid);
        end
        got_word        = bus.o_word;
        got.match_bytes = bus.o_match_bytes;
        got.location    = bus.o_location;
        got.zero        = bus.o_zero;
        got_cnt         = bus.o_dict_count;
        $display("txn word=%h mb=%0d loc=%0d zero=%0b count=%0d lat=%0d",
                 got_word, got.match_bytes, got.location, got.zero, got_cnt, got_lat);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        clear       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_word  = '0;
        bus.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b required 0", bus.o_valid); end
        checks++; if (bus.o_word !== 32'h0) begin errors++; $display("FAIL reset_o_word got=%h required 0", bus.o_word); end
        checks++; if (bus.o_match_bytes !== 3'd0) begin errors++; $display("FAIL reset_mb got=%0d required 0", bus.o_match_bytes); end
        checks++; if (bus.o_location !== 4'd0) begin errors++; $display("FAIL reset_loc got=%0d required 0", bus.o_location); end
        checks++; if (bus.o_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b required 0", bus.o_zero); end
        checks++; if (bus.o_dict_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d required 0", bus.o_dict_count); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready got=%b required 1", bus.o_ready); end
    endtask

    task automatic test_basic();
        send_one(32'h11223344);
        checks++; if (got_lat != 2) begin errors++; $display("FAIL basic_latency got=%0d required 2", got_lat); end
        checks++; if (got_word !== 32'h11223344) begin errors++; $display("FAIL basic_word got=%h required 11223344", got_word); end
        checks++; if (got.match_bytes !== 3'd0) begin errors++; $display("FAIL basic_first_mb got=%0d required 0", got.match_bytes); end
        checks++; if (got_cnt !== 5'd1) begin errors++; $display("FAIL basic_first_count got=%0d required 1", got_cnt); end
        send_one(32'h11223344);
        checks++; if (got.match_bytes !== 3'd4) begin errors++; $display("FAIL basic_repeat_mb got=%0d required 4", got.match_bytes); end
        checks++; if (got.location !== 4'd0) begin errors++; $display("FAIL basic_repeat_loc got=%0d required 0", got.location); end
        checks++; if (got_cnt !== 5'd1) begin errors++; $display("FAIL basic_repeat_count got=%0d required 1", got_cnt); end
    endtask

    task automatic test_partial();
        do_clear();
        send_one(32'hAABBCCDD);
        checks++; if (got_cnt !== 5'd1) begin errors++; $display("FAIL partial_seed_count got=%0d required 1", got_cnt); end
        send_one(32'hAABBCC00);
        checks++; if (got.match_bytes !== 3'd3) begin errors++; $display("FAIL partial3_mb got=%0d required 3", got.match_bytes); end
        checks++; if (got.location !== 4'd0) begin errors++; $display("FAIL partial3_loc got=%0d required 0", got.location); end
        send_one(32'hAA000000);
        checks++; if (got.match_bytes !== 3'd0) begin errors++; $display("FAIL below_min_mb got=%0d required 0", got.match_bytes); end
        checks++; if (got.location !== 4'd0) begin errors++; $display("FAIL below_min_loc got=%0d required 0", got.location); end
        checks++; if (got_cnt !== 5'd3) begin errors++; $display("FAIL below_min_count got=%0d required 3", got_cnt); end
    endtask

    task automatic test_zero();
        send_one(32'h00000000);
        checks++; if (got.zero !== 1'b1) begin errors++; $display("FAIL zero_flag got=%b required 1", got.zero); end
        checks++; if (got.match_bytes !== 3'd0) begin errors++; $display("FAIL zero_mb got=%0d required 0", got.match_bytes); end
        checks++; if (got_cnt !== 5'd3) begin errors++; $display("FAIL zero_count got=%0d required 3", got_cnt); end
        // AA000000 was stored at index 2 by the previous scenario
        send_one(32'hAA000000);
        checks++; if (got.zero !== 1'b0) begin errors++; $display("FAIL nonzero_flag got=%b required 0", got.zero); end
        checks++; if (got.match_bytes !== 3'd4) begin errors++; $display("FAIL after_zero_mb got=%0d required 4", got.match_bytes); end
        checks++; if (got.location !== 4'd2) begin errors++; $display("FAIL after_zero_loc got=%0d required 2", got.location); end
    endtask

    task automatic test_wrap();
        logic [7:0] hb;
        do_clear();
        for (int k = 0; k < 17; k++) begin
            hb = 8'h10 + 8'(k);
            send_one({hb, 24'h123456});
            checks++;
            if (got.match_bytes !== 3'd0) begin errors++; $display("FAIL wrap_fill_mb k=%0d got=%0d required 0", k, got.match_bytes); end
        end
        checks++; if (got_cnt !== 5'd16) begin errors++; $display("FAIL wrap_count_saturate got=%0d required 16", got_cnt); end
        send_one(32'h10123456);
        checks++; if (got.match_bytes !== 3'd0) begin errors++; $display("FAIL wrap_oldest_mb got=%0d required 0", got.match_bytes); end
        send_one(32'h20123456);
        checks++; if (got.match_bytes !== 3'd4) begin errors++; $display("FAIL wrap_newest_mb got=%0d required 4", got.match_bytes); end
        checks++; if (got.location !== 4'd0) begin errors++; $display("FAIL wrap_newest_loc got=%0d required 0", got.location); end
    endtask

    task automatic test_tie();
        logic [31:0] seed [8];
        seed[0] = 32'h01000000; seed[1] = 32'h02000000; seed[2] = 32'h03000000;
        seed[3] = 32'hCAFE0001; seed[4] = 32'h05000000; seed[5] = 32'h06000000;
        seed[6] = 32'h07000000; seed[7] = 32'hCAFE9999;
        do_clear();
        for (int i = 0; i < 8; i++) send_one(seed[i]);
        checks++; if (got_cnt !== 5'd8) begin errors++; $display("FAIL tie_fill_count got=%0d required 8", got_cnt); end
        send_one(32'hCAFE1234);
        checks++; if (got.match_bytes !== 3'd2) begin errors++; $display("FAIL tie_mb got=%0d required 2", got.match_bytes); end
        checks++; if (got.location !== 4'd3) begin errors++; $display("FAIL tie_loc got=%0d required 3", got.location); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [10];
        logic [31:0] held_word;
        logic        held_valid;
        logic        stable_ok;
        logic        saw_ready_low;
        int          sent;
        int          recv;
        int          cyc;
        do_clear();
        for (int i = 0; i < 10; i++) words[i] = {8'h40 + 8'(i), 24'hABCDEF};
        sent = 0; recv = 0; cyc = 0;
        held_valid = 1'b0; held_word = '0; stable_ok = 1'b1; saw_ready_low = 1'b0;
        while (recv < 10 && cyc < 80) begin
            bus.i_ready = !(cyc >= 3 && cyc < 8);
            if (sent < 10) begin
                bus.i_valid = 1'b1;
                bus.i_word  = words[sent];
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            if (held_valid && (bus.o_word !== held_word || bus.o_valid !== 1'b1)) stable_ok = 1'b0;
            if (!bus.o_ready) saw_ready_low = 1'b1;
            if (bus.i_valid && bus.o_ready) sent++;
            if (bus.o_valid && bus.i_ready) begin
                $display("txn burst idx=%0d word=%h mb=%0d count=%0d", recv, bus.o_word, bus.o_match_bytes, bus.o_dict_count);
                checks++;
                if (bus.o_word !== words[recv]) begin errors++; $display("FAIL burst_order idx=%0d got=%h required %h", recv, bus.o_word, words[recv]); end
                checks++;
                if (bus.o_dict_count !== 5'(recv + 1)) begin errors++; $display("FAIL burst_count idx=%0d got=%0d required %0d", recv, bus.o_dict_count, recv + 1); end
                recv++;
            end
            held_valid = bus.o_valid && !bus.i_ready;
            held_word  = bus.o_word;
            @(negedge clk);
            cyc++;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        checks++; if (recv != 10) begin errors++; $display("FAIL burst_received got=%0d required 10", recv); end
        checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL burst_stable got=%b required 1", stable_ok); end
        checks++; if (saw_ready_low !== 1'b1) begin errors++; $display("FAIL burst_ready_drop got=%b required 1", saw_ready_low); end
        @(negedge clk);
    endtask

    task automatic test_clear();
        do_clear();
        bus.i_valid = 1'b1;
        bus.i_word  = 32'h70AAAAAA;
        @(negedge clk);
        bus.i_word  = 32'h71AAAAAA;
        @(negedge clk);
        bus.i_word  = 32'h72AAAAAA;
        @(negedge clk);
        // 72AAAAAA sits in S1 with its write due at the next edge
        bus.i_word = 32'h73AAAAAA;
        clear      = 1'b1;
        #1;
        checks++; if (bus.o_dict_count !== 5'd2) begin errors++; $display("FAIL clear_pre_count got=%0d required 2", bus.o_dict_count); end
        @(negedge clk);
        clear       = 1'b0;
        bus.i_valid = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL clear_o_valid got=%b required 0", bus.o_valid); end
        checks++; if (bus.o_dict_count !== 5'd0) begin errors++; $display("FAIL clear_count got=%0d required 0", bus.o_dict_count); end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL clear_o_ready got=%b required 1", bus.o_ready); end
        @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL clear_no_ghost got=%b required 0", bus.o_valid); end
        send_one(32'h72AAAAAA);
        checks++; if (got.match_bytes !== 3'd0) begin errors++; $display("FAIL clear_pending_write_mb got=%0d required 0", got.match_bytes); end
        checks++; if (got_cnt !== 5'd1) begin errors++; $display("FAIL clear_after_count got=%0d required 1", got_cnt); end
        send_one(32'h70AAAAAA);
        checks++; if (got.match_bytes !== 3'd0) begin errors++; $display("FAIL clear_old_entry_mb got=%0d required 0", got.match_bytes); end
        checks++; if (got_cnt !== 5'd2) begin errors++; $display("FAIL clear_after_count2 got=%0d required 2", got_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_zero();
        test_wrap();
        test_tie();
        test_back_to_back();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
